// File: rtl/main_dec_pkg.sv
// Shared opcode constants, match patterns and the control-word type for the
// LEGv8 main decoder.
package main_dec_pkg;

    localparam int OP_W    = 11;
    localparam int ALUOP_W = 2;

    localparam logic [OP_W-1:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [OP_W-1:0] OP_STUR = 11'b111_1100_0000;

    // CBZ ignores the low three bits; R-format covers ADD/SUB/AND/ORR.
    localparam logic [OP_W-1:0] OP_CBZ_MASK  = 11'b111_1111_1000;
    localparam logic [OP_W-1:0] OP_CBZ_VAL   = 11'b101_1010_0000;
    localparam logic [OP_W-1:0] OP_RFMT_MASK = 11'b100_1111_0111;
    localparam logic [OP_W-1:0] OP_RFMT_VAL  = 11'b100_0101_0000;

    localparam logic [ALUOP_W-1:0] ALUOP_MEM = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;

    typedef struct packed {
        logic               reg2loc;
        logic               alusrc;
        logic               memtoreg;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
        logic               not_an_instr;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

endpackage

// File: rtl/main_dec_comb.sv
// Purely combinational opcode-to-control decode; first matching class wins,
// anything unmatched (including unknown opcode bits) falls to the default row.
module main_dec_comb
    import main_dec_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o              = CTRL_ZERO;
        ctrl_o.not_an_instr = 1'b1;
        // Equality tests evaluate false on unknown bits, steering them to default.
        if (op_i == OP_LDUR) begin
            ctrl_o.alusrc       = 1'b1;
            ctrl_o.memtoreg     = 1'b1;
            ctrl_o.regwrite     = 1'b1;
            ctrl_o.memread      = 1'b1;
            ctrl_o.aluop        = ALUOP_MEM;
            ctrl_o.not_an_instr = 1'b0;
        end else if (op_i == OP_STUR) begin
            ctrl_o.reg2loc      = 1'b1;
            ctrl_o.alusrc       = 1'b1;
            ctrl_o.memwrite     = 1'b1;
            ctrl_o.aluop        = ALUOP_MEM;
            ctrl_o.not_an_instr = 1'b0;
        end else if ((op_i & OP_CBZ_MASK) == OP_CBZ_VAL) begin
            ctrl_o.reg2loc      = 1'b1;
            ctrl_o.branch       = 1'b1;
            ctrl_o.aluop        = ALUOP_BR;
            ctrl_o.not_an_instr = 1'b0;
        end else if ((op_i & OP_RFMT_MASK) == OP_RFMT_VAL) begin
            ctrl_o.regwrite     = 1'b1;
            ctrl_o.aluop        = ALUOP_R;
            ctrl_o.not_an_instr = 1'b0;
        end
    end

endmodule

// File: rtl/main_dec.sv
// LEGv8 main control decoder: one registered stage over main_dec_comb,
// cleared asynchronously by the active-low reset.
module main_dec
    import main_dec_pkg::*;
#(
    parameter int OP_W    = main_dec_pkg::OP_W,
    parameter int ALUOP_W = main_dec_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    Op,
    output logic               Reg2Loc,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               NotAnInstr
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    main_dec_comb u_comb (
        .op_i   (Op),
        .ctrl_o (ctrl_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= CTRL_ZERO;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign Reg2Loc    = ctrl_q.reg2loc;
    assign ALUSrc     = ctrl_q.alusrc;
    assign MemtoReg   = ctrl_q.memtoreg;
    assign RegWrite   = ctrl_q.regwrite;
    assign MemRead    = ctrl_q.memread;
    assign MemWrite   = ctrl_q.memwrite;
    assign Branch     = ctrl_q.branch;
    assign ALUOp      = ctrl_q.aluop;
    assign NotAnInstr = ctrl_q.not_an_instr;

endmodule

// File: tb/tb_main_dec.sv
// Self-checking bench for main_dec: wildcard-table reference model checked
// every cycle, plus literal expectations for each instruction class.
module tb_main_dec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] Op = '0;
    logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, NotAnInstr;
    logic [1:0]  ALUOp;

    int n_pass  = 0;
    int n_total = 0;

    // Packed view {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,NotAnInstr}
    localparam logic [9:0] V_LDUR = 10'b0_1_1_1_1_0_0_00_0;
    localparam logic [9:0] V_STUR = 10'b1_1_0_0_0_1_0_00_0;
    localparam logic [9:0] V_CBZ  = 10'b1_0_0_0_0_0_1_01_0;
    localparam logic [9:0] V_RFMT = 10'b0_0_0_1_0_0_0_10_0;
    localparam logic [9:0] V_DEF  = 10'b0_0_0_0_0_0_0_00_1;
    localparam logic [9:0] V_ZERO = 10'b0;

    main_dec dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Reg2Loc    (Reg2Loc),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .ALUOp      (ALUOp),
        .NotAnInstr (NotAnInstr)
    );

    always #5 clk = ~clk;

    wire [9:0] dut_vec = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead,
                          MemWrite, Branch, ALUOp, NotAnInstr};

    // Reference decode straight from the instruction-class table.
    function automatic logic [9:0] model(input logic [10:0] op);
        if (op ==? 11'b111_1100_0010) return V_LDUR;
        if (op ==? 11'b111_1100_0000) return V_STUR;
        if (op ==? 11'b101_1010_0???) return V_CBZ;
        if (op ==? 11'b1??_0101_?000) return V_RFMT;
        return V_DEF;
    endfunction

    logic [9:0] exp_q = '0;
    always @(posedge clk or negedge reset) begin
        if (!reset) exp_q <= '0;
        else        exp_q <= model(Op);
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    always @(negedge clk) check("model_cycle", dut_vec, exp_q);

    // Apply an opcode at the falling edge and check the literal result after the next rise.
    task automatic issue(input string name, input logic [10:0] op, input logic [9:0] req);
        @(negedge clk);
        Op = op;
        @(posedge clk);
        #1;
        check(name, dut_vec, req);
    endtask

    initial begin
        logic [10:0] xop;
        #1 reset = 1'b0;
        Op = 11'b111_1100_0010;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", dut_vec, V_ZERO);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check("ldur_after_reset", dut_vec, V_LDUR);

        issue("stur", 11'b111_1100_0000, V_STUR);

        for (int i = 0; i < 8; i++) begin
            issue($sformatf("cbz_%0d", i), 11'b101_1010_0000 | 11'(i), V_CBZ);
        end

        issue("add", 11'b100_0101_1000, V_RFMT);
        issue("sub", 11'b110_0101_1000, V_RFMT);
        issue("and", 11'b100_0101_0000, V_RFMT);
        issue("orr", 11'b101_0101_0000, V_RFMT);
        issue("rfmt_near_miss", 11'b110_0101_1001, V_DEF);
        issue("cbz_near_miss", 11'b101_1010_1000, V_DEF);
        issue("ldur_near_miss", 11'b111_1100_0011, V_DEF);
        issue("all_ones", 11'b111_1111_1111, V_DEF);

        xop = 11'b0xx_xxxx_xxxx;
        issue("x_opcode", xop, V_DEF);
        n_total++;
        if (!$isunknown(dut_vec)) n_pass++;
        else $display("FAIL x_propagation: got %b, expected no unknown bits", dut_vec);

        // Asynchronous clear in the high phase, before the next edge.
        issue("ldur_before_async", 11'b111_1100_0010, V_LDUR);
        #2 reset = 1'b0;
        #1 check("async_reset", dut_vec, V_ZERO);
        @(posedge clk);
        #1 check("async_reset_held", dut_vec, V_ZERO);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check("ldur_after_async", dut_vec, V_LDUR);

        issue("stur_b2b", 11'b111_1100_0000, V_STUR);
        issue("cbz_b2b", 11'b101_1010_0101, V_CBZ);
        issue("ldur_b2b", 11'b111_1100_0010, V_LDUR);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 50000");
        $fatal(1);
    end

endmodule

// File: doc/main_dec.md
Name: main_dec

Overview:
- Main control decoder for the single-cycle/pipelined LEGv8 datapath.
- Decodes the 11-bit opcode field (instr[31:21]) into the datapath control signals: Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp.
- Outputs are registered: one clock of latency, cleared by reset.
- Feeds the register file, ALU-source mux, data memory, branch logic and the ALU decoder (aludec).

Parameters:
- OP_W, 11, opcode width.
- ALUOP_W, 2, ALUOp width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Op  input  11  opcode (instr[31:21]).
- Reg2Loc  output  1  register-file read-port-2 select (1 = Rt field, 0 = Rm field).
- ALUSrc  output  1  ALU operand B select (1 = sign-extended immediate).
- MemtoReg  output  1  write-back select (1 = memory data).
- RegWrite  output  1  register-file write enable.
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- Branch  output  1  conditional-branch (CBZ) indicator.
- ALUOp  output  2  ALU operation class to aludec.
- NotAnInstr  output  1  1 when Op matches no supported class.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset==0, asynchronous): all outputs are 0, including ALUOp=00 and NotAnInstr=0. Outputs stay 0 until the first rising clk edge after reset deasserts.
- On each rising clk edge, the outputs register the combinational decode of Op. Latency is exactly 1 cycle, with no handshake.
- Decode table, in priority order (first match wins). Each entry lists Reg2Loc.ALUSrc.MemtoReg.RegWrite.MemRead.MemWrite.Branch.ALUOp:
  - LDUR, Op==111_1100_0010: 0.1.1.1.1.0.0.00
  - STUR, Op==111_1100_0000: 1.1.0.0.0.1.0.00
  - CBZ, Op matches 101_1010_0xxx (low 3 bits ignored): 1.0.0.0.0.0.1.01
  - R-format, Op matches 1xx_0101_x000, covering ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: 0.0.0.1.0.0.0.10
  - Default (any other Op): 0.0.0.0.0.0.0.00 with NotAnInstr=1.
- Don't-care fields are fixed to 0 for determinism: Reg2Loc for LDUR, MemtoReg for STUR.
- NotAnInstr is 0 for every listed class.
- An X/Z bit on Op resolves to the default row; no X may propagate to the outputs.
- If reset asserts mid-operation, the outputs clear immediately, independent of clk.
- Back-to-back opcode changes each cycle produce a matching output sequence, delayed by one cycle.

Decomposition:
- Shared package main_dec_pkg holds:
  - opcode constants OP_LDUR, OP_STUR;
  - wildcard patterns OP_CBZ_MASK/VAL and OP_RFMT_MASK/VAL;
  - typedef ctrl_t, a packed struct of the eight control fields plus NotAnInstr;
  - localparams for ALUOp codes ALUOP_MEM=00, ALUOP_BR=01, ALUOP_R=10.
- One natural sub-module: main_dec_comb, the purely combinational opcode-to-ctrl_t decoder.
- The top-level main_dec holds only the asynchronous-reset register stage.

Test Plan:
- Reset: hold reset=0 with Op=111_1100_0010 and toggle clk -> all outputs 0. Release reset; after 1 edge -> 0.1.1.1.1.0.0.00, NotAnInstr=0.
- STUR Op=111_1100_0000 -> after 1 edge 1.1.0.0.0.1.0.00.
- CBZ: sweep Op=101_1010_0000 through 101_1010_0111 -> each yields 1.0.0.0.0.0.1.01 one cycle later.
- R-format: apply ADD, SUB (110_0101_1000), AND, ORR back-to-back on consecutive cycles -> 0.0.0.1.0.0.0.10 every cycle with 1-cycle lag. The near-miss 110_0101_1001 yields default.
- Default: Op=111_1111_1111 -> 0.0.0.0.0.0.0.00 with NotAnInstr=1. An Op containing X -> same default, no X on the outputs.
- Asynchronous reset mid-stream: assert reset between clk edges while LDUR outputs are held -> outputs go 0 immediately, before the next edge.
